// File: rtl/pi_request_queue_pkg.sv
// Shared definitions for the Pi request queue: register indices, commit word
// decode positions, queue entry layout and size codes.
package pi_request_queue_pkg;

  localparam logic [2:0] PI_REG_DATA_LO = 3'd0;
  localparam logic [2:0] PI_REG_DATA_HI = 3'd1;
  localparam logic [2:0] PI_REG_ADDR_LO = 3'd2;
  localparam logic [2:0] PI_REG_ADDR_HI = 3'd3;

  localparam logic [1:0] SIZE_BYTE_WORD = 2'b01;
  localparam logic [1:0] SIZE_LONG      = 2'b11;

  // Bit positions inside the 16-bit commit word written to PI_REG_ADDR_HI
  localparam int unsigned CMD_ADDR_HI_LSB = 0;
  localparam int unsigned CMD_SIZE_LSB    = 8;
  localparam int unsigned CMD_READ_BIT    = 10;
  localparam int unsigned CMD_FC_LSB      = 11;

  // Queue entry, MSB first: fc | read | size | addr | wdata
  typedef struct packed {
    logic [2:0]  fc;
    logic        read;
    logic [1:0]  size;
    logic [23:0] addr;
    logic [31:0] wdata;
  } req_entry_t;

  localparam int unsigned ENTRY_W         = $bits(req_entry_t);
  localparam int unsigned ENTRY_WDATA_LSB = 0;
  localparam int unsigned ENTRY_ADDR_LSB  = 32;
  localparam int unsigned ENTRY_SIZE_LSB  = 56;
  localparam int unsigned ENTRY_READ_BIT  = 58;
  localparam int unsigned ENTRY_FC_LSB    = 59;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_WAIT
  } issue_state_t;

  function automatic req_entry_t build_entry(input logic [15:0] cmd,
                                             input logic [15:0] addr_lo,
                                             input logic [31:0] wdata);
    req_entry_t e;
    e.fc    = cmd[CMD_FC_LSB +: 3];
    e.read  = cmd[CMD_READ_BIT];
    e.size  = cmd[CMD_SIZE_LSB +: 2];
    e.addr  = {cmd[CMD_ADDR_HI_LSB +: 8], addr_lo};
    e.wdata = wdata;
    return e;
  endfunction

endpackage

// File: rtl/pi_request_queue_if.sv
// Request/completion channel between the Pi request queue and the 68k bus engine.
interface pi_request_queue_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_read;
  logic [2:0]        req_fc;
  logic [31:0]       req_wdata;
  logic              bus_done;
  logic              bus_berr;
  logic [31:0]       bus_rdata;

  modport master (
    output req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
    input  req_ready, bus_done, bus_berr, bus_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
    output req_ready, bus_done, bus_berr, bus_rdata
  );
endinterface

// File: rtl/pi_req_fifo.sv
// Synchronous first-word-fall-through FIFO with flush. Pointers carry one
// extra wrap bit so count is a plain pointer difference.
module pi_req_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 62
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push at full is dropped even when a pop frees a slot the same cycle
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PTR_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr[IDX_W-1:0]];

  // Pointer update; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage write; cleared on reset so head fields read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[IDX_W-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/pi_request_queue.sv
// Collects Pi register writes into complete 68k bus requests, queues them and
// issues one at a time to the bus engine, capturing read data and status.
module pi_request_queue
  import pi_request_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 24
) (
  input  logic                   sys_clk,
  input  logic                   nSYS_RESET,
  input  logic                   pi_wr_strobe,
  input  logic [2:0]             pi_a,
  input  logic [15:0]            pi_data_in,
  input  logic                   q_flush,
  input  logic                   status_clear,
  pi_request_queue_if.master     bus,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_full,
  output logic                   busy,
  output logic                   overflow_flag,
  output logic                   berr_flag
);
  logic [15:0]        wdata_lo;
  logic [15:0]        wdata_hi;
  logic [15:0]        addr_lo;
  logic               commit;
  logic               commit_read;
  req_entry_t         new_entry;
  req_entry_t         head;
  logic [ENTRY_W-1:0] head_bits;
  logic               fifo_empty;
  logic               handshake;
  logic               in_flight;
  logic               inflight_read;
  logic               done_ok;
  issue_state_t       state;
  issue_state_t       state_next;

  assign commit      = pi_wr_strobe && (pi_a == PI_REG_ADDR_HI);
  assign commit_read = commit && pi_data_in[CMD_READ_BIT];
  assign new_entry   = build_entry(pi_data_in, addr_lo, {wdata_hi, wdata_lo});
  assign head        = req_entry_t'(head_bits);

  // Staging registers; they persist across commits for reuse
  always_ff @(posedge sys_clk or negedge nSYS_RESET) begin
    if (!nSYS_RESET) begin
      wdata_lo <= '0;
      wdata_hi <= '0;
      addr_lo  <= '0;
    end else if (pi_wr_strobe) begin
      case (pi_a)
        PI_REG_DATA_LO: wdata_lo <= pi_data_in;
        PI_REG_DATA_HI: wdata_hi <= pi_data_in;
        PI_REG_ADDR_LO: addr_lo  <= pi_data_in;
        default: ;
      endcase
    end
  end

  pi_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (nSYS_RESET),
    .push  (commit),
    .wdata (new_entry),
    .pop   (handshake),
    .flush (q_flush),
    .rdata (head_bits),
    .count (q_count),
    .full  (q_full),
    .empty (fifo_empty)
  );

  assign in_flight = (state == ISSUE_WAIT);
  assign handshake = bus.req_valid && bus.req_ready;
  assign done_ok   = bus.bus_done && in_flight;

  assign bus.req_valid = !fifo_empty && !in_flight;
  assign bus.req_addr  = ADDR_W'(head.addr);
  assign bus.req_size  = head.size;
  assign bus.req_read  = head.read;
  assign bus.req_fc    = head.fc;
  assign bus.req_wdata = head.wdata;

  assign busy = (q_count != '0) || in_flight;

  // Issue state register
  always_ff @(posedge sys_clk or negedge nSYS_RESET) begin
    if (!nSYS_RESET) state <= ISSUE_IDLE;
    else             state <= state_next;
  end

  // One outstanding request: accept on handshake, release on bus_done
  always_comb begin
    state_next = state;
    case (state)
      ISSUE_IDLE: if (handshake)    state_next = ISSUE_WAIT;
      ISSUE_WAIT: if (bus.bus_done) state_next = ISSUE_IDLE;
      default:                      state_next = ISSUE_IDLE;
    endcase
  end

  // Remember whether the issued request is a read
  always_ff @(posedge sys_clk or negedge nSYS_RESET) begin
    if (!nSYS_RESET)    inflight_read <= 1'b0;
    else if (handshake) inflight_read <= head.read;
  end

  // Read completion capture; a committed read invalidates the previous result
  always_ff @(posedge sys_clk or negedge nSYS_RESET) begin
    if (!nSYS_RESET) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (done_ok && inflight_read) begin
      rd_data  <= bus.bus_rdata;
      rd_valid <= 1'b1;
    end else if (commit_read) begin
      rd_valid <= 1'b0;
    end
  end

  // Sticky status flags; a set beats a concurrent clear
  always_ff @(posedge sys_clk or negedge nSYS_RESET) begin
    if (!nSYS_RESET) begin
      overflow_flag <= 1'b0;
      berr_flag     <= 1'b0;
    end else begin
      if (commit && q_full)         overflow_flag <= 1'b1;
      else if (status_clear)        overflow_flag <= 1'b0;
      if (done_ok && bus.bus_berr)  berr_flag     <= 1'b1;
      else if (status_clear)        berr_flag     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pi_request_queue.sv
// Directed bench for pi_request_queue: table-driven single transfer plus
// hand-written posting, flush, bus error, ordering and reset sequences.
module tb_pi_request_queue;
  logic        sys_clk = 1'b0;
  logic        nSYS_RESET;
  logic        pi_wr_strobe;
  logic [2:0]  pi_a;
  logic [15:0] pi_data_in;
  logic        q_flush;
  logic        status_clear;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  q_count;
  logic        q_full;
  logic        busy;
  logic        overflow_flag;
  logic        berr_flag;

  int n_cmp = 0;
  int n_err = 0;

  pi_request_queue_if #(.ADDR_W(24)) bus ();

  pi_request_queue #(.DEPTH(8), .ADDR_W(24)) dut (
    .sys_clk       (sys_clk),
    .nSYS_RESET    (nSYS_RESET),
    .pi_wr_strobe  (pi_wr_strobe),
    .pi_a          (pi_a),
    .pi_data_in    (pi_data_in),
    .q_flush       (q_flush),
    .status_clear  (status_clear),
    .bus           (bus.master),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .q_count       (q_count),
    .q_full        (q_full),
    .busy          (busy),
    .overflow_flag (overflow_flag),
    .berr_flag     (berr_flag)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        strobe;
    logic [2:0]  a;
    logic [15:0] d;
    logic        ready;
    logic        done;
    logic        ev;
    logic [23:0] eaddr;
    logic [31:0] ewdata;
    logic [1:0]  esize;
    logic [3:0]  ecount;
    logic        ebusy;
    logic        erdv;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pi_write(input logic [2:0] a, input logic [15:0] d);
    pi_wr_strobe = 1'b1;
    pi_a         = a;
    pi_data_in   = d;
    tick();
    pi_wr_strobe = 1'b0;
  endtask

  task automatic done_pulse(input logic berr, input logic [31:0] rdata);
    bus.bus_done  = 1'b1;
    bus.bus_berr  = berr;
    bus.bus_rdata = rdata;
    tick();
    bus.bus_done  = 1'b0;
    bus.bus_berr  = 1'b0;
  endtask

  logic [23:0] exp_addr [3];
  logic        exp_read [3];

  initial begin
    nSYS_RESET    = 1'b0;
    pi_wr_strobe  = 1'b0;
    pi_a          = '0;
    pi_data_in    = '0;
    q_flush       = 1'b0;
    status_clear  = 1'b0;
    bus.req_ready = 1'b0;
    bus.bus_done  = 1'b0;
    bus.bus_berr  = 1'b0;
    bus.bus_rdata = '0;

    //          strb  a     d         rdy   done  ev    addr        wdata         size   cnt   busy  rdv
    vecs[0] = '{1'b1, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 24'h000000, 32'h00000000, 2'b00, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 24'h000000, 32'h00000000, 2'b00, 4'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 3'd2, 16'h5678, 1'b0, 1'b0, 1'b0, 24'h000000, 32'h00000000, 2'b00, 4'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 3'd3, 16'h01BF, 1'b0, 1'b0, 1'b1, 24'hBF5678, 32'h00001234, 2'b01, 4'd1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 24'h000000, 32'h00000000, 2'b00, 4'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 24'h000000, 32'h00000000, 2'b00, 4'd0, 1'b0, 1'b0};

    tick();
    tick();
    check("rst_req_valid", 64'(bus.req_valid), 64'd0);
    check("rst_q_count",   64'(q_count),       64'd0);
    check("rst_rd_data",   64'(rd_data),       64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    nSYS_RESET = 1'b1;
    tick();
    check("rst_rel_count", 64'(q_count), 64'd0);

    // Single write through the vector table
    foreach (vecs[i]) begin
      pi_wr_strobe = vecs[i].strobe;
      pi_a         = vecs[i].a;
      pi_data_in   = vecs[i].d;
      bus.req_ready = vecs[i].ready;
      bus.bus_done  = vecs[i].done;
      tick();
      check($sformatf("v%0d_valid", i), 64'(bus.req_valid), 64'(vecs[i].ev));
      check($sformatf("v%0d_count", i), 64'(q_count),       64'(vecs[i].ecount));
      check($sformatf("v%0d_busy",  i), 64'(busy),          64'(vecs[i].ebusy));
      check($sformatf("v%0d_rdv",   i), 64'(rd_valid),      64'(vecs[i].erdv));
      if (vecs[i].ev) begin
        check($sformatf("v%0d_addr",  i), 64'(bus.req_addr),  64'(vecs[i].eaddr));
        check($sformatf("v%0d_wdata", i), 64'(bus.req_wdata), 64'(vecs[i].ewdata));
        check($sformatf("v%0d_size",  i), 64'(bus.req_size),  64'(vecs[i].esize));
        check($sformatf("v%0d_read",  i), 64'(bus.req_read),  64'd0);
      end
    end
    pi_wr_strobe = 1'b0;
    bus.req_ready = 1'b0;
    bus.bus_done  = 1'b0;

    // Posting: fill to 8, overflow on the 9th, clear, push at full with pop
    for (int i = 0; i < 8; i++) pi_write(3'd3, 16'h01BF);
    check("post_count8", 64'(q_count),       64'd8);
    check("post_full",   64'(q_full),        64'd1);
    check("post_ovf0",   64'(overflow_flag), 64'd0);
    pi_write(3'd3, 16'h01BF);
    check("ovf_set",     64'(overflow_flag), 64'd1);
    check("ovf_count",   64'(q_count),       64'd8);
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    check("ovf_clear",   64'(overflow_flag), 64'd0);
    bus.req_ready = 1'b1;
    pi_write(3'd3, 16'h01BF);
    bus.req_ready = 1'b0;
    check("full_pushpop_count", 64'(q_count),       64'd7);
    check("full_pushpop_ovf",   64'(overflow_flag), 64'd1);
    check("full_pushpop_valid", 64'(bus.req_valid), 64'd0);
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    q_flush = 1'b1;
    pi_write(3'd3, 16'h01BF);
    q_flush = 1'b0;
    check("flush_commit_count", 64'(q_count), 64'd0);
    check("flush_commit_busy",  64'(busy),    64'd1);
    done_pulse(1'b0, 32'h0);
    check("flush_done_busy", 64'(busy),     64'd0);
    check("flush_done_rdv",  64'(rd_valid), 64'd0);

    // Push+pop at count 3, then flush with 4 queued and a read in flight
    pi_write(3'd3, 16'h05BF);
    pi_write(3'd3, 16'h01BF);
    pi_write(3'd3, 16'h01BF);
    check("pp3_pre_count", 64'(q_count), 64'd3);
    bus.req_ready = 1'b1;
    pi_write(3'd3, 16'h01BF);
    bus.req_ready = 1'b0;
    check("pp3_count", 64'(q_count), 64'd3);
    check("pp3_busy",  64'(busy),    64'd1);
    pi_write(3'd3, 16'h01BF);
    check("pp3_count4", 64'(q_count), 64'd4);
    q_flush = 1'b1; tick(); q_flush = 1'b0;
    check("flush4_count", 64'(q_count),     64'd0);
    check("flush4_busy",  64'(busy),        64'd1);
    check("flush4_valid", 64'(bus.req_valid), 64'd0);
    done_pulse(1'b0, 32'hCAFEF00D);
    check("flush4_rd_data", 64'(rd_data),  64'hCAFEF00D);
    check("flush4_rdv",     64'(rd_valid), 64'd1);
    check("flush4_idle",    64'(busy),     64'd0);

    // Bus error on a read
    pi_write(3'd3, 16'h05BF);
    check("berr_commit_rdv", 64'(rd_valid), 64'd0);
    bus.req_ready = 1'b1; tick(); bus.req_ready = 1'b0;
    done_pulse(1'b1, 32'h11112222);
    check("berr_flag",    64'(berr_flag), 64'd1);
    check("berr_rdv",     64'(rd_valid),  64'd1);
    check("berr_rd_data", 64'(rd_data),   64'h11112222);
    check("berr_busy",    64'(busy),      64'd0);
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    check("berr_clear",   64'(berr_flag), 64'd0);
    check("berr_rdv_keep", 64'(rd_valid), 64'd1);

    // Ordering: A write, B read, C write with a 5-cycle bus engine
    exp_addr[0] = 24'h11AAAA; exp_read[0] = 1'b0;
    exp_addr[1] = 24'h22BBBB; exp_read[1] = 1'b1;
    exp_addr[2] = 24'h33CCCC; exp_read[2] = 1'b0;
    pi_write(3'd2, 16'hAAAA);
    pi_write(3'd3, 16'h0111);
    check("ord_a_rdv", 64'(rd_valid), 64'd1);
    pi_write(3'd2, 16'hBBBB);
    pi_write(3'd3, 16'h0522);
    check("ord_b_rdv", 64'(rd_valid), 64'd0);
    pi_write(3'd2, 16'hCCCC);
    pi_write(3'd3, 16'h0133);
    check("ord_count", 64'(q_count), 64'd3);
    bus.req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 20 && !bus.req_valid; w++) tick();
      check($sformatf("ord%0d_valid", i), 64'(bus.req_valid), 64'd1);
      check($sformatf("ord%0d_addr",  i), 64'(bus.req_addr),  64'(exp_addr[i]));
      check($sformatf("ord%0d_read",  i), 64'(bus.req_read),  64'(exp_read[i]));
      tick();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("ord%0d_single_%0d", i, k), 64'(bus.req_valid), 64'd0);
        tick();
      end
      done_pulse(1'b0, 32'hDEADBEEF);
      if (i >= 1) begin
        check($sformatf("ord%0d_rdv",  i), 64'(rd_valid), 64'd1);
        check($sformatf("ord%0d_rdat", i), 64'(rd_data),  64'hDEADBEEF);
      end
    end
    check("ord_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a transfer
    pi_write(3'd3, 16'h01BF);
    pi_write(3'd3, 16'h01BF);
    check("arst_pre_busy", 64'(busy), 64'd1);
    #2;
    nSYS_RESET = 1'b0;
    #1;
    check("arst_valid",    64'(bus.req_valid), 64'd0);
    check("arst_count",    64'(q_count),       64'd0);
    check("arst_busy",     64'(busy),          64'd0);
    check("arst_rd_data",  64'(rd_data),       64'd0);
    check("arst_rdv",      64'(rd_valid),      64'd0);
    check("arst_full",     64'(q_full),        64'd0);
    check("arst_flags",    64'({overflow_flag, berr_flag}), 64'd0);
    bus.req_ready = 1'b0;
    tick();
    nSYS_RESET = 1'b1;
    tick();
    check("arst_rel_valid", 64'(bus.req_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
